instr_sequencer: RTL and testbench

//  Upstream instruction feeder for the 4-register bus processor (proc). Holds a small

---
 rtl/instr_sequencer_pkg.sv | 41 ++++
 rtl/instr_sequencer_if.sv | 34 +++
 rtl/instr_sequencer_mem.sv | 28 ++
 rtl/instr_sequencer.sv | 119 +++++++++++
 tb/tb_instr_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// ==== instr_sequencer_pkg : shared word layout, opcodes and FSM states (rev 1.0) ====
`default_nettype none

package instr_sequencer_pkg;

  localparam int IW       = 15;
  localparam int HALT_BIT = 14;
  localparam int F_HI     = 13;
  localparam int F_LO     = 12;
  localparam int RX_HI    = 11;
  localparam int RX_LO    = 10;
  localparam int RY_HI    = 9;
  localparam int RY_LO    = 8;
  localparam int DATA_HI  = 7;
  localparam int DATA_LO  = 0;

  localparam logic [1:0] F_MV  = 2'b00;
  localparam logic [1:0] F_MVI = 2'b01;
  localparam logic [1:0] F_ADD = 2'b10;
  localparam logic [1:0] F_SUB = 2'b11;

  typedef logic [IW-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  function automatic word_t make_word(input logic halt, input logic [1:0] f,
                                      input logic [1:0] rx, input logic [1:0] ry,
                                      input logic [7:0] data);
    return {halt, f, rx, ry, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ==== instr_sequencer_if : load/run control and proc-side bus of the sequencer (rev 1.0) ====
`default_nettype none

interface instr_sequencer_if #(parameter int AW = 4);
  import instr_sequencer_pkg::*;

  logic          start;
  logic          load_en;
  logic [AW-1:0] load_addr;
  word_t         load_word;
  logic          done;
  logic          w;
  logic [1:0]    f;
  logic [1:0]    rx;
  logic [1:0]    ry;
  logic [7:0]    data;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          error;

  modport master (
    output start, load_en, load_addr, load_word, done,
    input  w, f, rx, ry, data, pc, busy, halted, error
  );

  modport slave (
    input  start, load_en, load_addr, load_word, done,
    output w, f, rx, ry, data, pc, busy, halted, error
  );

endinterface

`default_nettype wire

// File: rtl/instr_sequencer_mem.sv
// ==== instr_mem : 2**AW x 15 program RAM, no reset (rev 1.0) ====
`default_nettype none

module instr_mem
  import instr_sequencer_pkg::*;
#(
  parameter int AW = 4
) (
  input  wire logic          clk,
  input  wire logic          wr_en,
  input  wire logic [AW-1:0] wr_addr,
  input  wire word_t         wr_data,
  input  wire logic [AW-1:0] rd_addr,
  output      word_t         rd_data
);

  word_t r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // The read is registered by the sequencer's IR, which keeps a reset value.
  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ==== instr_sequencer : fetches program words and issues them to proc, one per Done (rev 1.0) ====
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input wire logic       clk,
  input wire logic       rst_n,
  instr_sequencer_if.slave bus
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PC_LAST = '1;
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_pc, w_pc_n;
  logic [TW-1:0] r_timer, w_timer_n;
  word_t         r_ir, w_ir_n;
  logic          r_halted, w_halted_n;
  logic          r_error, w_error_n;
  word_t         w_rd_data;
  logic          w_busy;

  assign w_busy = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);

  instr_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (bus.load_en && !w_busy),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_word),
    .rd_addr (r_pc),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_timer  <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_timer  <= w_timer_n;
      r_ir     <= w_ir_n;
      r_halted <= w_halted_n;
      r_error  <= w_error_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_timer_n  = r_timer;
    w_ir_n     = r_ir;
    w_halted_n = r_halted;
    w_error_n  = r_error;
    case (r_state)
      S_IDLE, S_HALT, S_ERR: begin
        if (bus.start) begin
          w_pc_n     = '0;
          w_halted_n = 1'b0;
          w_error_n  = 1'b0;
          w_state_n  = S_FETCH;
        end
      end
      S_FETCH: begin
        w_ir_n    = w_rd_data;
        w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_ir[HALT_BIT]) begin
          w_halted_n = 1'b1;
          w_state_n  = S_HALT;
        end else begin
          w_timer_n  = '0;
          w_state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done in the last allowed WAIT cycle still wins over the timeout.
        if (bus.done) begin
          if (r_pc == PC_LAST) begin
            w_halted_n = 1'b1;
            w_state_n  = S_HALT;
          end else begin
            w_pc_n     = r_pc + 1'b1;
            w_state_n  = S_FETCH;
          end
        end else if (r_timer == T_LAST) begin
          w_error_n = 1'b1;
          w_state_n = S_ERR;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.w      = (r_state == S_ISSUE) && !r_ir[HALT_BIT];
  assign bus.f      = r_ir[F_HI:F_LO];
  assign bus.rx     = r_ir[RX_HI:RX_LO];
  assign bus.ry     = r_ir[RY_HI:RY_LO];
  assign bus.data   = r_ir[DATA_HI:DATA_LO];
  assign bus.pc     = r_pc;
  assign bus.busy   = w_busy;
  assign bus.halted = r_halted;
  assign bus.error  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ==== tb_instr_sequencer : scoreboard bench with a program-level reference model (rev 1.0) ====
`default_nettype none

module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int AW      = 4;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 2**AW;

  typedef struct {
    bit    is_end;
    word_t word;
    int    pc;
    int    cyc;
    int    hold_until;
    bit    halted;
    bit    err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  word_t mem_m [DEPTH];
  exp_t  exp_q [$];
  int    delay_q [$];

  instr_sequencer_if #(.AW(AW)) bus ();

  instr_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Program-level model: walk the program word by word and derive, from the
  // chosen Done delay of each instruction, when it is issued and how the run ends.
  // fixed_d >= 0 fixes every delay (0 = Done never comes); -1 random with
  // occasional timeouts; -2 random without timeouts.
  task automatic plan_run(input int fixed_d, input int s);
    int   p = 0;
    int   t = s + 1;
    int   d;
    bit   fin = 0;
    exp_t e;
    while (!fin) begin
      e = '{is_end: 0, word: mem_m[p], pc: p, cyc: t, hold_until: 0, halted: 0, err: 0};
      if (mem_m[p][HALT_BIT]) begin
        e.is_end = 1; e.halted = 1; e.cyc = t + 1;
        exp_q.push_back(e);
        fin = 1;
      end else begin
        if (fixed_d >= 0) d = fixed_d;
        else if (fixed_d == -1 && $urandom_range(0, 9) == 0) d = 0;
        else d = $urandom_range(1, TIMEOUT);
        delay_q.push_back(d);
        e.hold_until = t + ((d == 0) ? TIMEOUT : d);
        exp_q.push_back(e);
        e.is_end = 1;
        if (d == 0) begin
          e.err = 1; e.cyc = t + TIMEOUT + 1;
          exp_q.push_back(e);
          fin = 1;
        end else if (p == DEPTH - 1) begin
          e.halted = 1; e.cyc = t + d + 1;
          exp_q.push_back(e);
          fin = 1;
        end else begin
          p++;
          t = t + d + 2;
        end
      end
    end
  endtask

  task automatic load(input int addr, input word_t wd);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = AW'(addr); bus.load_word = wd;
    mem_m[addr] = wd;
    @(posedge clk); #1;
    bus.load_en = 1'b0;
  endtask

  task automatic start_run(input int fixed_d, input bit ld0, input word_t wd0);
    @(negedge clk);
    if (ld0) begin
      mem_m[0] = wd0;
      bus.load_en = 1'b1; bus.load_addr = '0; bus.load_word = wd0;
    end
    plan_run(fixed_d, cyc + 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.load_en = 1'b0;
    check("start_clears", {29'd0, bus.busy, bus.halted, bus.error}, 32'h4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 500 && (bus.busy || exp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_total++;
      $display("FAIL run_end_timeout: busy=%0b, %0d expected events left", bus.busy, exp_q.size());
      exp_q.delete(); delay_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_w();
    int n = 0;
    while (n < 100 && !bus.w) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL wait_issue_timeout: w never seen");
    end
  endtask

  // Done responder: raises Done for one cycle in the planned WAIT cycle.
  initial begin
    int d;
    bus.done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.w) begin
        d = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
        if (d > 0) begin
          @(posedge clk);
          repeat (d - 1) @(posedge clk);
          #1 bus.done = 1'b1;
          @(posedge clk);
          #1 bus.done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops an expectation on every issue strobe and on every run end.
  initial begin
    exp_t  e;
    bit    prev_busy = 0;
    word_t last_word = '0;
    int    last_pc = 0;
    int    hold_from = 0;
    int    hold_until = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 0;
        hold_until = -1;
      end else begin
        if (bus.w) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_issue: pc=%0d at cycle %0d", bus.pc, cyc);
          end else begin
            e = exp_q.pop_front();
            check("issue_kind", {31'd0, e.is_end}, 32'd0);
            check("issue_cycle", cyc, e.cyc);
            check("issue_fields", {18'd0, bus.f, bus.rx, bus.ry, bus.data}, {18'd0, e.word[13:0]});
            check("issue_pc", {28'd0, bus.pc}, e.pc);
            last_word = e.word; last_pc = e.pc;
            hold_from = cyc; hold_until = e.hold_until;
          end
        end else if (cyc > hold_from && cyc <= hold_until) begin
          check("wait_stable_fields", {18'd0, bus.f, bus.rx, bus.ry, bus.data}, {18'd0, last_word[13:0]});
          check("wait_stable_pc_w", {27'd0, bus.w, bus.pc}, last_pc);
        end
        if (prev_busy && !bus.busy) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_end: pc=%0d at cycle %0d", bus.pc, cyc);
          end else begin
            e = exp_q.pop_front();
            check("end_kind", {31'd0, e.is_end}, 32'd1);
            check("end_cycle", cyc, e.cyc);
            check("end_status", {30'd0, bus.halted, bus.error}, {30'd0, e.halted, e.err});
            check("end_pc", {28'd0, bus.pc}, e.pc);
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.load_en = 1'b0; bus.load_addr = '0; bus.load_word = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {18'd0, bus.f, bus.rx, bus.ry, bus.data}, 32'd0);
    check("reset_status", {25'd0, bus.w, bus.busy, bus.halted, bus.error, bus.pc}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // mvi R0,#05 then HALT
    load(0, make_word(1'b0, F_MVI, 2'd0, 2'd0, 8'h05));
    load(1, make_word(1'b1, F_MV, 2'd0, 2'd0, 8'h00));
    start_run(1, 0, '0);
    wait_idle();

    // add R1,R2 with Done in the 3rd WAIT cycle
    load(0, make_word(1'b0, F_ADD, 2'd1, 2'd2, 8'h3C));
    start_run(3, 0, '0);
    wait_idle();

    // Done never comes, then a fresh Start clears Error
    load(0, make_word(1'b0, F_SUB, 2'd3, 2'd1, 8'hA7));
    start_run(0, 0, '0);
    wait_idle();
    start_run(-2, 0, '0);
    wait_idle();

    // Load and Start while busy are both ignored
    load(0, make_word(1'b0, F_MV, 2'd1, 2'd0, 8'h11));
    load(1, make_word(1'b0, F_MV, 2'd2, 2'd1, 8'h22));
    load(2, make_word(1'b0, F_MV, 2'd3, 2'd2, 8'h33));
    load(3, make_word(1'b0, F_MVI, 2'd0, 2'd3, 8'hA5));
    load(4, make_word(1'b1, F_MV, 2'd0, 2'd0, 8'h00));
    start_run(5, 0, '0);
    wait_w();
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = 4'd3; bus.load_word = make_word(1'b0, F_SUB, 2'd1, 2'd1, 8'h5A);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.load_en = 1'b0; bus.start = 1'b0;
    wait_idle();
    start_run(-2, 0, '0);
    wait_idle();

    // 16 mv words with no HALT: stops at the last address without wrapping
    for (int i = 0; i < DEPTH; i++)
      load(i, make_word(1'b0, F_MV, 2'($urandom), 2'($urandom), 8'($urandom)));
    start_run(-2, 0, '0);
    wait_idle();

    // Asynchronous reset in the middle of WAIT; program survives
    load(0, make_word(1'b0, F_MV, 2'd2, 2'd3, 8'h99));
    load(1, make_word(1'b1, F_MV, 2'd0, 2'd0, 8'h00));
    start_run(0, 0, '0);
    wait_w();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midwait_reset_outputs", {18'd0, bus.f, bus.rx, bus.ry, bus.data}, 32'd0);
    check("midwait_reset_status", {25'd0, bus.w, bus.busy, bus.halted, bus.error, bus.pc}, 32'd0);
    exp_q.delete(); delay_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_run(-2, 0, '0);
    wait_idle();

    // Random programs; one run also writes mem[0] in the Start cycle
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, make_word(($urandom_range(0, 4) == 0), 2'($urandom), 2'($urandom),
                          2'($urandom), 8'($urandom)));
      start_run(-1, (r == 2), make_word(1'b0, F_MVI, 2'd1, 2'd1, 8'hC3));
      wait_idle();
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
